// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: state encoding and lamp patterns,
// used by the controller and by the display logic.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR1   = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR2   = 3'd5,
    FLASH = 3'd6
  } tl_state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  function automatic logic is_all_red(input tl_state_e s);
    return (s == AR1) || (s == AR2);
  endfunction

endpackage

// File: rtl/tl_event_det.sv
// Rising-edge detector for a level handshake: one event per low-to-high
// transition of 'in', no matter how long the level is held.
module tl_event_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic event_out
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign event_out = in & ~prev_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller with all-red clearance phases,
// optional pedestrian walk service and flashing-yellow night/fault mode.
module traffic_light_ctrl
  import tl_pkg::*;
#(
  parameter bit PED_ENABLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pulse,
  input  logic       timeout,
  input  logic       flash,
  input  logic       ped_req,
  output logic       mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  tl_state_e state_q, state_d;
  logic      ped_q, ped_d;
  logic      served_q, served_d;
  logic      toggle_q, toggle_d;
  logic      tmo_event;
  logic      det_rst_n;
  logic      entering_ar;

  // Leaving FLASH also clears the edge register so a held timeout counts anew.
  assign det_rst_n = rst_n & ~((state_q == FLASH) & ~flash);

  tl_event_det u_tmo_det (
    .clk       (clk),
    .rst_n     (det_rst_n),
    .in        (timeout),
    .event_out (tmo_event)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= NS_G;
      ped_q    <= 1'b0;
      served_q <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ped_q    <= ped_d;
      served_q <= served_d;
      toggle_q <= toggle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flash) begin
      state_d = FLASH;
    end else begin
      case (state_q)
        NS_G:    if (tmo_event) state_d = NS_Y;
        NS_Y:    if (tmo_event) state_d = AR1;
        AR1:     if (tmo_event) state_d = EW_G;
        EW_G:    if (tmo_event) state_d = EW_Y;
        EW_Y:    if (tmo_event) state_d = AR2;
        AR2:     if (tmo_event) state_d = NS_G;
        FLASH:   state_d = AR2;
        default: state_d = NS_G;
      endcase
    end
  end

  assign entering_ar = is_all_red(state_d) && (state_d != state_q);

  // A request arriving in the very cycle it is served stays pending for the next all-red.
  always_comb begin
    ped_d    = ped_q;
    served_d = served_q;
    toggle_d = 1'b0;
    if (!((state_q == FLASH) && (state_d == FLASH))) begin
      if (entering_ar) begin
        ped_d = 1'b0;
      end
      if (ped_req) begin
        ped_d = 1'b1;
      end
    end
    if (entering_ar) begin
      served_d = ped_q;
    end else if (!is_all_red(state_d)) begin
      served_d = 1'b0;
    end
    if (state_d == FLASH) begin
      if (state_q != FLASH) begin
        toggle_d = 1'b1;
      end else begin
        toggle_d = pulse ? ~toggle_q : toggle_q;
      end
    end
    if (!PED_ENABLE) begin
      ped_d    = 1'b0;
      served_d = 1'b0;
    end
  end

  always_comb begin
    mode     = 1'b1;
    ns_light = RED;
    ew_light = RED;
    walk     = 1'b0;
    phase    = state_q;
    case (state_q)
      NS_G: begin
        mode     = 1'b0;
        ns_light = GRN;
      end
      NS_Y: ns_light = YEL;
      EW_G: begin
        mode     = 1'b0;
        ew_light = GRN;
      end
      EW_Y: ew_light = YEL;
      AR1, AR2: walk = served_q;
      FLASH: begin
        ns_light = toggle_q ? YEL : OFF;
        ew_light = toggle_q ? YEL : OFF;
      end
      default: begin
        mode     = 1'b0;
        ns_light = GRN;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: stimulus pushes expected outputs
// into a scoreboard queue that a separate monitor drains and compares.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, pulse, timeout, flash, ped_req;
  logic       mode, walk;
  logic [2:0] ns_light, ew_light, phase;

  always #5 clk = ~clk;

  traffic_light_ctrl #(.PED_ENABLE(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse    (pulse),
    .timeout  (timeout),
    .flash    (flash),
    .ped_req  (ped_req),
    .mode     (mode),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
  );

  typedef struct {
    string       name;
    logic [10:0] vec;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Expected {mode, ns, ew, walk, phase} from the phase table.
  function automatic logic [10:0] exp_vec(input int ph, input bit w, input bit tg);
    logic [2:0] ns, ew;
    logic       m;
    m  = 1'b1;
    ns = 3'b100;
    ew = 3'b100;
    case (ph)
      0: begin m = 1'b0; ns = 3'b001; end
      1: ns = 3'b010;
      3: begin m = 1'b0; ew = 3'b001; end
      4: ew = 3'b010;
      6: begin ns = {1'b0, tg, 1'b0}; ew = {1'b0, tg, 1'b0}; end
      default: ;
    endcase
    return {m, ns, ew, w, 3'(ph)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit r, input bit p, input bit t, input bit f, input bit q);
    rst_n   = r;
    pulse   = p;
    timeout = t;
    flash   = f;
    ped_req = q;
    step();
  endtask

  task automatic checkOutput(input string name, input int ph, input bit w, input bit tg = 1'b0);
    exp_t e;
    e.name = name;
    e.vec  = exp_vec(ph, w, tg);
    sb.push_back(e);
  endtask

  task automatic tev(input string name, input int ph, input bit w);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput(name, ph, w);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput({name, "_hold"}, ph, w);
  endtask

  always @(posedge clk) begin
    exp_t        e;
    logic [10:0] act;
    #2;
    act = {mode, ns_light, ew_light, walk, phase};
    if (^{ns_light, ew_light} !== 1'bx) begin
      checks++;
      if ((ns_light[0] & ew_light[0]) || ($countones(ns_light) > 1) || ($countones(ew_light) > 1)) begin
        errors++;
        $display("[TB] FAIL lamp_safety: ns=%b ew=%b required no dual green, at most one lamp each", ns_light, ew_light);
      end
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("[TB] FAIL %s: got {mode,ns,ew,walk,phase}=%b required %b", e.name, act, e.vec);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("reset", 0, 0);
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("reset_hold", 0, 0);

    applyStimulus(1, 0, 1, 0, 0);  checkOutput("held_tmo_adv", 1, 0);
    applyStimulus(1, 0, 1, 0, 0);  checkOutput("held_tmo_2", 1, 0);
    applyStimulus(1, 0, 1, 0, 0);  checkOutput("held_tmo_3", 1, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("held_tmo_low", 1, 0);

    applyStimulus(0, 0, 0, 0, 0);  checkOutput("reset_b", 0, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("seq_start", 0, 0);
    tev("seq_ns_y", 1, 0);
    tev("seq_ar1", 2, 0);
    tev("seq_ew_g", 3, 0);
    tev("seq_ew_y", 4, 0);
    tev("seq_ar2", 5, 0);
    tev("seq_ns_g", 0, 0);

    tev("ped_ns_y", 1, 0);
    tev("ped_ar1", 2, 0);
    tev("ped_ew_g", 3, 0);
    applyStimulus(1, 0, 0, 0, 1);  checkOutput("ped_press", 3, 0);
    tev("ped_ew_y", 4, 0);
    tev("ped_ar2_walk", 5, 1);
    tev("ped_ns_g_nowalk", 0, 0);
    tev("ped_ns_y2", 1, 0);
    tev("ped_ar1_cleared", 2, 0);

    tev("rearm_ew_g", 3, 0);
    tev("rearm_ew_y", 4, 0);
    applyStimulus(1, 0, 0, 0, 1);  checkOutput("rearm_press", 4, 0);
    applyStimulus(1, 0, 1, 0, 1);  checkOutput("rearm_ar2_walk", 5, 1);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("rearm_ar2_hold", 5, 1);
    tev("rearm_ns_g", 0, 0);
    tev("rearm_ns_y", 1, 0);
    tev("rearm_ar1_walk", 2, 1);
    tev("rearm_ew_g2", 3, 0);

    applyStimulus(1, 0, 1, 1, 0);  checkOutput("flash_entry", 6, 0, 1);
    applyStimulus(1, 1, 0, 1, 0);  checkOutput("flash_p1", 6, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);  checkOutput("flash_nopulse", 6, 0, 0);
    applyStimulus(1, 1, 0, 1, 0);  checkOutput("flash_p2", 6, 0, 1);
    applyStimulus(1, 1, 0, 1, 0);  checkOutput("flash_p3", 6, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);  checkOutput("flash_tmo_ignored", 6, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);  checkOutput("flash_tmo_low", 6, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("flash_exit_ar2", 5, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("flash_exit_hold", 5, 0);
    tev("flash_exit_ns_g", 0, 0);

    applyStimulus(1, 0, 0, 1, 0);  checkOutput("flash2_entry", 6, 0, 1);
    applyStimulus(1, 0, 1, 1, 0);  checkOutput("flash2_tmo_high", 6, 0, 1);
    applyStimulus(1, 0, 1, 0, 0);  checkOutput("flash2_exit_ar2", 5, 0);
    applyStimulus(1, 0, 1, 0, 0);  checkOutput("flash2_edge_cleared", 0, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("flash2_ns_g_hold", 0, 0);

    tev("rst_ns_y", 1, 0);
    tev("rst_ar1", 2, 0);
    tev("rst_ew_g", 3, 0);
    tev("rst_ew_y", 4, 0);
    applyStimulus(1, 0, 0, 0, 1);  checkOutput("rst_press", 4, 0);
    applyStimulus(0, 0, 0, 0, 0);  checkOutput("rst_mid_phase", 0, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("rst_resume", 0, 0);
    tev("rst_ns_y2", 1, 0);
    tev("rst_ar1_nowalk", 2, 0);

    applyStimulus(1, 0, 0, 1, 0);  checkOutput("rst_flash_entry", 6, 0, 1);
    applyStimulus(0, 0, 0, 1, 0);  checkOutput("rst_over_flash", 0, 0);
    applyStimulus(1, 0, 0, 0, 0);  checkOutput("rst_flash_resume", 0, 0);

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
